// File: rtl/m3_dequant_writer.sv
// Dequantizes one 8x8 block of zigzag-ordered coefficients and writes each
// result to SRAM at its raster position, one write per accepted coefficient.
module m3_dequant_writer #(
    parameter int          ROW_STRIDE = 320,
    parameter logic [35:0] Q1_SHIFTS  = {4'd4, 4'd3, 4'd3, 4'd2, 4'd2, 4'd1, 4'd1, 4'd1, 4'd3},
    parameter logic [35:0] Q0_SHIFTS  = {4'd6, 4'd5, 4'd5, 4'd4, 4'd4, 4'd3, 4'd3, 4'd2, 4'd3}
) (
    input  logic        CLOCK_50_I,
    input  logic        reset,
    input  logic        start,
    input  logic [17:0] base_addr,
    input  logic        q_sel,
    input  logic        coef_valid,
    input  logic [15:0] coef_data,
    output logic        coef_ready,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        busy,
    output logic        block_done,
    output logic        dbg_state
);

    // Handshake: a coefficient transfers on a rising edge where coef_valid and
    // coef_ready are both high; coef_ready is high exactly while in RUN.

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Zigzag index -> raster position {row, col}.
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    state_t             state;
    state_t             state_next;
    logic [6:0]         k;
    logic [17:0]        base_lat;
    logic               q_lat;
    logic               hs;
    logic               start_ok;
    logic [5:0]         pos;
    logic [2:0]         row;
    logic [2:0]         col;
    logic [3:0]         diag;
    logic [3:0]         diag_sel;
    logic [3:0]         amt;
    logic signed [23:0] wide;
    logic [15:0]        clipped;
    logic [17:0]        addr_next;

    assign coef_ready = (state == RUN);
    assign hs         = coef_valid && (state == RUN);
    assign start_ok   = start && (state == IDLE);
    assign busy       = (state == RUN) || block_done;
    assign dbg_state  = state;

    always_ff @(posedge CLOCK_50_I) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (hs && (k == 7'd63)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pos       = ZZ[k[5:0]];
        row       = pos[5:3];
        col       = pos[2:0];
        diag      = {1'b0, row} + {1'b0, col};
        diag_sel  = (diag >= 4'd8) ? 4'd8 : diag;
        amt       = q_lat ? Q1_SHIFTS[{diag_sel, 2'b00} +: 4] : Q0_SHIFTS[{diag_sel, 2'b00} +: 4];
        wide      = {{8{coef_data[15]}}, coef_data} <<< amt;
        clipped   = wide[15:0];
        if (wide > 24'sd32767) begin
            clipped = 16'h7FFF;
        end else if (wide < -24'sd32768) begin
            clipped = 16'h8000;
        end
        // 18-bit arithmetic gives the required wrap-around for free.
        addr_next = base_lat + 18'(row) * 18'(ROW_STRIDE) + 18'(col);
    end

    // Reset clears the output registers, so a write pending from the handshake
    // sampled in the same edge never appears.
    always_ff @(posedge CLOCK_50_I) begin
        if (reset) begin
            k               <= 7'd0;
            base_lat        <= 18'd0;
            q_lat           <= 1'b0;
            SRAM_we_n       <= 1'b1;
            SRAM_address    <= 18'd0;
            SRAM_write_data <= 16'd0;
            block_done      <= 1'b0;
        end else begin
            SRAM_we_n  <= 1'b1;
            block_done <= 1'b0;
            if (start_ok) begin
                k        <= 7'd0;
                base_lat <= base_addr;
                q_lat    <= q_sel;
            end
            if (hs) begin
                k               <= k + 7'd1;
                SRAM_we_n       <= 1'b0;
                SRAM_address    <= addr_next;
                SRAM_write_data <= clipped;
                block_done      <= (k == 7'd63);
            end
        end
    end

endmodule

// File: tb/tb_m3_dequant_writer.sv
// Directed bench for m3_dequant_writer: block addressing, shift tables,
// clipping, valid gaps, ignored start, back-to-back blocks and mid-block reset.
module tb_m3_dequant_writer;

    logic        CLOCK_50_I = 1'b0;
    logic        reset      = 1'b1;
    logic        start      = 1'b0;
    logic [17:0] base_addr  = '0;
    logic        q_sel      = 1'b0;
    logic        coef_valid = 1'b0;
    logic [15:0] coef_data  = '0;
    logic        coef_ready;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic        busy;
    logic        block_done;
    logic        dbg_state;

    m3_dequant_writer dut (
        .CLOCK_50_I      (CLOCK_50_I),
        .reset           (reset),
        .start           (start),
        .base_addr       (base_addr),
        .q_sel           (q_sel),
        .coef_valid      (coef_valid),
        .coef_data       (coef_data),
        .coef_ready      (coef_ready),
        .SRAM_address    (SRAM_address),
        .SRAM_write_data (SRAM_write_data),
        .SRAM_we_n       (SRAM_we_n),
        .busy            (busy),
        .block_done      (block_done),
        .dbg_state       (dbg_state)
    );

    always #5 CLOCK_50_I = ~CLOCK_50_I;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [17:0] wa_q[$];
    logic [15:0] wd_q[$];
    int          wc_q[$];
    int          done_cnt = 0;
    int          done_at  = 0;
    logic [15:0] coefs[64];

    always @(posedge CLOCK_50_I) cyc <= cyc + 1;

    // Write log, sampled mid-cycle.
    always @(negedge CLOCK_50_I) begin
        if (SRAM_we_n === 1'b0) begin
            wa_q.push_back(SRAM_address);
            wd_q.push_back(SRAM_write_data);
            wc_q.push_back(cyc);
        end
        if (block_done === 1'b1) begin
            done_cnt++;
            done_at = wa_q.size();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLOCK_50_I);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        done_cnt = 0;
        done_at  = 0;
    endtask

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < 64; i++) coefs[i] = v;
    endtask

    // Feeds coefs[0..n-1]; returns mid-cycle after the last handshake's write.
    task automatic send_block(input logic [17:0] base, input logic q, input bit gap,
                              input bit skip_start, input int n);
        int b;
        if (!skip_start) begin
            start = 1'b1; base_addr = base; q_sel = q;
            tick();
            start = 1'b0;
            chk("busy_after_start", 32'(busy), 32'd1);
        end
        for (int i = 0; i < n; i++) begin
            coef_valid = 1'b1;
            coef_data  = coefs[i];
            b = 0;
            while (!coef_ready && b < 16) begin tick(); b++; end
            chk("ready_before_hs", 32'(coef_ready), 32'd1);
            if (gap && i == 32) begin
                start = 1'b1; base_addr = 18'd9000; q_sel = 1'b1;
            end
            tick();
            start = 1'b0;
            if (gap && i < n - 1) begin
                coef_valid = 1'b0;
                tick();
            end
        end
        coef_valid = 1'b0;
        @(negedge CLOCK_50_I);
        #1;
    endtask

    initial begin
        // Reset values
        tick(); tick();
        chk("rst_ready", 32'(coef_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(block_done), 32'd0);
        chk("rst_we_n", 32'(SRAM_we_n), 32'd1);
        chk("rst_addr", 32'(SRAM_address), 32'd0);
        chk("rst_data", 32'(SRAM_write_data), 32'd0);

        // coef_valid in IDLE does nothing
        reset = 1'b0; coef_valid = 1'b1; coef_data = 16'd1;
        tick(); tick(); tick();
        chk("idle_ready", 32'(coef_ready), 32'd0);
        @(negedge CLOCK_50_I); #1;
        chk("idle_no_write", 32'(wa_q.size()), 32'd0);
        coef_valid = 1'b0;

        // Basic block, Q0, all ones
        fill(16'd1); clear_log();
        send_block(18'd76800, 1'b0, 1'b0, 1'b0, 64);
        chk("b1_done_pulse", 32'(block_done), 32'd1);
        chk("b1_busy_last", 32'(busy), 32'd1);
        chk("b1_we_last", 32'(SRAM_we_n), 32'd0);
        chk("b1_count", 32'(wa_q.size()), 32'd64);
        chk("b1_a0", 32'(wa_q[0]), 32'd76800);
        chk("b1_d0", 32'(wd_q[0]), 32'd8);
        chk("b1_a1", 32'(wa_q[1]), 32'd76801);
        chk("b1_d1", 32'(wd_q[1]), 32'd4);
        chk("b1_a2", 32'(wa_q[2]), 32'd77120);
        chk("b1_d2", 32'(wd_q[2]), 32'd4);
        chk("b1_a63", 32'(wa_q[63]), 32'd79047);
        chk("b1_d63", 32'(wd_q[63]), 32'd64);
        chk("b1_done_cnt", 32'(done_cnt), 32'd1);
        chk("b1_done_at", 32'(done_at), 32'd64);
        chk("b1_contig", 32'(wc_q[63] - wc_q[0]), 32'd63);
        tick();
        chk("b1_after_done", 32'(block_done), 32'd0);
        chk("b1_after_busy", 32'(busy), 32'd0);
        chk("b1_after_we", 32'(SRAM_we_n), 32'd1);
        chk("b1_hold_addr", 32'(SRAM_address), 32'd79047);
        chk("b1_hold_data", 32'(SRAM_write_data), 32'd64);
        chk("b1_after_ready", 32'(coef_ready), 32'd0);

        // Q1 with a negative value
        fill(16'd0); coefs[1] = 16'hFFFB; coefs[2] = 16'd3; coefs[63] = 16'd1;
        clear_log();
        send_block(18'd1000, 1'b1, 1'b0, 1'b0, 64);
        chk("q1_d0", 32'(wd_q[0]), 32'd0);
        chk("q1_a1", 32'(wa_q[1]), 32'd1001);
        chk("q1_d1", 32'(wd_q[1]), 32'h0000FFF6);
        chk("q1_a2", 32'(wa_q[2]), 32'd1320);
        chk("q1_d2", 32'(wd_q[2]), 32'd6);
        chk("q1_d63", 32'(wd_q[63]), 32'd16);
        tick();

        // Positive clip
        fill(16'd0); coefs[62] = 16'hFFFD; coefs[63] = 16'd2000;
        clear_log();
        send_block(18'd100, 1'b0, 1'b0, 1'b0, 64);
        chk("clip_pos", 32'(wd_q[63]), 32'h00007FFF);
        chk("neg_shift62", 32'(wd_q[62]), 32'h0000FF40);
        chk("addr62", 32'(wa_q[62]), 32'd2346);
        tick();

        // Negative clip with address wrap-around
        fill(16'd0); coefs[63] = 16'hF830;
        clear_log();
        send_block(18'h3FFFF, 1'b0, 1'b0, 1'b0, 64);
        chk("clip_neg", 32'(wd_q[63]), 32'h00008000);
        chk("wrap_a0", 32'(wa_q[0]), 32'h0003FFFF);
        chk("wrap_a63", 32'(wa_q[63]), 32'd2246);
        tick();

        // Valid gaps plus a start pulse mid-block
        fill(16'd2); clear_log();
        send_block(18'd5000, 1'b0, 1'b1, 1'b0, 64);
        chk("gap_count", 32'(wa_q.size()), 32'd64);
        chk("gap_spacing", 32'(wc_q[1] - wc_q[0]), 32'd2);
        chk("gap_a33", 32'(wa_q[33]), 32'd6602);
        chk("gap_d33", 32'(wd_q[33]), 32'd64);
        chk("gap_a63", 32'(wa_q[63]), 32'd7247);
        chk("gap_d63", 32'(wd_q[63]), 32'd128);
        chk("gap_done_cnt", 32'(done_cnt), 32'd1);
        tick();

        // Back-to-back blocks: start in the block_done cycle
        fill(16'd1); clear_log();
        send_block(18'd20000, 1'b0, 1'b0, 1'b0, 64);
        chk("bb_first_done", 32'(block_done), 32'd1);
        chk("bb_first_count", 32'(wa_q.size()), 32'd64);
        clear_log();
        start = 1'b1; base_addr = 18'd30000; q_sel = 1'b0;
        tick();
        start = 1'b0;
        chk("bb_ready_next", 32'(coef_ready), 32'd1);
        chk("bb_busy_next", 32'(busy), 32'd1);
        send_block(18'd30000, 1'b0, 1'b0, 1'b1, 64);
        chk("bb_a0", 32'(wa_q[0]), 32'd30000);
        chk("bb_d0", 32'(wd_q[0]), 32'd8);
        chk("bb_count", 32'(wa_q.size()), 32'd64);
        chk("bb_done_cnt", 32'(done_cnt), 32'd1);
        tick();

        // Reset after 20 handshakes, colliding with handshake index 20
        fill(16'd1); clear_log();
        send_block(18'd40000, 1'b0, 1'b0, 1'b0, 20);
        coef_valid = 1'b1; coef_data = 16'd1; reset = 1'b1;
        tick();
        chk("mr_we_n", 32'(SRAM_we_n), 32'd1);
        chk("mr_addr", 32'(SRAM_address), 32'd0);
        chk("mr_data", 32'(SRAM_write_data), 32'd0);
        chk("mr_ready", 32'(coef_ready), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_done", 32'(block_done), 32'd0);
        @(negedge CLOCK_50_I); #1;
        chk("mr_count", 32'(wa_q.size()), 32'd20);
        reset = 1'b0;
        tick(); tick(); tick();
        chk("mr_no_ready", 32'(coef_ready), 32'd0);
        @(negedge CLOCK_50_I); #1;
        chk("mr_count_after", 32'(wa_q.size()), 32'd20);
        coef_valid = 1'b0;

        // Fresh block after reset restarts at k=0
        clear_log();
        send_block(18'd50000, 1'b0, 1'b0, 1'b0, 64);
        chk("post_a0", 32'(wa_q[0]), 32'd50000);
        chk("post_d0", 32'(wd_q[0]), 32'd8);
        chk("post_count", 32'(wa_q.size()), 32'd64);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
